// File: rtl/sys_defs.sv
// sys_defs: shared FSM state, access-size codes and byte-enable patterns for the memory stage.
package sys_defs;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;
  localparam logic [2:0] MEM_BYTE = 3'b000;
  localparam logic [2:0] MEM_HALF = 3'b001;
  localparam logic [2:0] MEM_WORD = 3'b010;
  localparam logic [2:0] MEM_BYTEU = 3'b100;
  localparam logic [2:0] MEM_HALFU = 3'b101;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic illegal_access(input logic [2:0] f3, input logic [1:0] a);
    return f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[1:0] == MEM_HALF[1:0] && a[0]) ||
           (f3[1:0] == MEM_WORD[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword lane of a load word and sign- or zero-extends it.
module load_align
  import sys_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = rdata[{addr[1], 4'b0000} +: 16];
  always_comb
    result = funct3 == MEM_BYTE  ? {{24{b[7]}}, b} :
             funct3 == MEM_BYTEU ? {24'b0, b} :
             funct3 == MEM_HALF  ? {{16{h[15]}}, h} :
             funct3 == MEM_HALFU ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a req/gnt/rvalid bus; stalls upstream while an access is in flight.
module mem_stage
  import sys_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_regb,
  input  logic [2:0]  ex_mem_funct3,
  input  logic        mem2proc_gnt,
  input  logic        mem2proc_rvalid,
  input  logic [31:0] mem2proc_rdata,
  output logic        proc2mem_req,
  output logic        proc2mem_we,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_wdata,
  output logic [3:0]  proc2mem_be,
  output logic [31:0] mem_result_out,
  output logic        mem_stall_out,
  output logic        mem_done_out,
  output logic        mem_err_out
);
  mem_state_t  state;
  logic [31:0] addr_r, wdata_r, result_r, wdata_n, load_data;
  logic [3:0]  be_r, be_n;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic        we_r, err_r, mem_op, bad;
  assign mem_op = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
  assign bad = illegal_access(ex_mem_funct3, ex_mem_alu_result[1:0]);
  always_comb begin
    be_n = ex_mem_funct3[1:0] == MEM_BYTE[1:0] ? BE_BYTE << ex_mem_alu_result[1:0] :
           ex_mem_funct3[1:0] == MEM_HALF[1:0] ? BE_HALF << ex_mem_alu_result[1:0] : BE_WORD;
    wdata_n = ex_mem_funct3[1:0] == MEM_BYTE[1:0] ? {4{ex_mem_regb[7:0]}} :
              ex_mem_funct3[1:0] == MEM_HALF[1:0] ? {2{ex_mem_regb[15:0]}} : ex_mem_regb;
  end
  load_align u_align (.rdata(mem2proc_rdata), .addr(lane_r), .funct3(f3_r), .result(load_data));
  // rvalid only matters while a load owns the bus (REQ after gnt, or WAIT)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr_r <= '0;
      wdata_r <= '0;
      result_r <= '0;
      be_r <= '0;
      f3_r <= '0;
      lane_r <= '0;
      we_r <= 1'b0;
      err_r <= 1'b0;
    end else
      case (state)
        IDLE: if (mem_op) begin
          addr_r <= {ex_mem_alu_result[31:2], 2'b00};
          wdata_r <= wdata_n;
          be_r <= be_n;
          f3_r <= ex_mem_funct3;
          lane_r <= ex_mem_alu_result[1:0];
          we_r <= ~ex_mem_rd_mem;
          err_r <= bad;
          result_r <= '0;
          state <= bad ? DONE : REQ;
        end
        REQ: if (mem2proc_gnt) begin
          if (!we_r && mem2proc_rvalid) result_r <= load_data;
          state <= (we_r || mem2proc_rvalid) ? DONE : WAIT;
        end
        WAIT: if (mem2proc_rvalid) begin
          result_r <= load_data;
          state <= DONE;
        end
        DONE: begin
          err_r <= 1'b0;
          state <= IDLE;
        end
      endcase
  assign proc2mem_req = state == REQ;
  assign proc2mem_we = proc2mem_req & we_r;
  assign proc2mem_be = proc2mem_req ? be_r : '0;
  assign proc2mem_addr = addr_r;
  assign proc2mem_wdata = wdata_r;
  assign mem_done_out = state == DONE;
  assign mem_err_out = mem_done_out & err_r;
  assign mem_stall_out = rst & ((state == IDLE & mem_op) | state == REQ | state == WAIT);
  assign mem_result_out = mem_done_out ? result_r : (state == IDLE && rst) ? ex_mem_alu_result : '0;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a reactive bus responder.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        ex_mem_valid_inst = 1'b0, ex_mem_rd_mem = 1'b0, ex_mem_wr_mem = 1'b0;
  logic [31:0] ex_mem_alu_result = '0, ex_mem_regb = '0;
  logic [2:0]  ex_mem_funct3 = '0;
  logic        mem2proc_gnt = 1'b0, mem2proc_rvalid = 1'b0;
  logic [31:0] mem2proc_rdata = '0;
  logic        proc2mem_req, proc2mem_we, mem_stall_out, mem_done_out, mem_err_out;
  logic [31:0] proc2mem_addr, proc2mem_wdata, mem_result_out;
  logic [3:0]  proc2mem_be;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [3:0]  be;
    int          gd, ww;
    bit          same;
  } bus_t;
  typedef struct {
    logic [31:0] r;
    logic        e;
  } res_t;
  bus_t bq[$];
  res_t rq[$];
  int n_checks = 0, n_pass = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid_inst(ex_mem_valid_inst), .ex_mem_rd_mem(ex_mem_rd_mem), .ex_mem_wr_mem(ex_mem_wr_mem),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_regb(ex_mem_regb), .ex_mem_funct3(ex_mem_funct3),
    .mem2proc_gnt(mem2proc_gnt), .mem2proc_rvalid(mem2proc_rvalid), .mem2proc_rdata(mem2proc_rdata),
    .proc2mem_req(proc2mem_req), .proc2mem_we(proc2mem_we), .proc2mem_addr(proc2mem_addr),
    .proc2mem_wdata(proc2mem_wdata), .proc2mem_be(proc2mem_be), .mem_result_out(mem_result_out),
    .mem_stall_out(mem_stall_out), .mem_done_out(mem_done_out), .mem_err_out(mem_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic illegal(input logic [2:0] f3, input logic [31:0] a);
    return f3 == 3 || f3 == 6 || f3 == 7 || (f3[1:0] == 1 && a[0]) || (f3[1:0] == 2 && a[1:0] != 0);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] rdata, input int off, input logic [2:0] f3);
    logic [31:0] v;
    v = rdata >> (8 * off);
    if (f3 == 0 || f3 == 4) begin
      v = v & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (f3 == 1 || f3 == 5) begin
      v = v & 32'hFFFF;
      if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
    end else v = rdata;
    return v;
  endfunction

  task automatic issue(input bit v, input bit rd, input bit wr, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic [31:0] rdata, input int gd, input bit same, input int ww);
    bit memop, il;
    int off, sz, expn, got;
    bus_t b;
    res_t r;
    memop = v && (rd || wr);
    il = memop && illegal(f3, alu);
    off = int'(alu[1:0]);
    sz = int'(f3[1:0]);
    expn = 0;
    if (memop) begin
      if (!il) begin
        b.addr = alu & 32'hFFFF_FFFC;
        b.we = !rd;
        b.be = sz == 0 ? 4'(1 << off) : sz == 1 ? 4'(3 << off) : 4'hF;
        b.wdata = sz == 0 ? rs2[7:0] * 32'h0101_0101 : sz == 1 ? rs2[15:0] * 32'h0001_0001 : rs2;
        b.rdata = rdata;
        b.gd = gd;
        b.same = same;
        b.ww = ww;
        bq.push_back(b);
      end
      r.e = il;
      r.r = (il || !rd) ? 32'h0 : extend(rdata, off, f3);
      rq.push_back(r);
      expn = il ? 1 : (!rd || same) ? 2 + gd : 3 + gd + ww;
    end
    @(posedge clk);
    #1;
    ex_mem_valid_inst = v;
    ex_mem_rd_mem = rd;
    ex_mem_wr_mem = wr;
    ex_mem_alu_result = alu;
    ex_mem_regb = rs2;
    ex_mem_funct3 = f3;
    if (!memop) begin
      @(negedge clk);
      check("passthru", {mem_result_out, mem_stall_out, proc2mem_req, mem_done_out}, {alu, 3'b000});
    end else begin
      got = -1;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (mem_done_out) got = n;
        if (!mem_stall_out) break;
      end
      check("latency", got, expn);
    end
  endtask

  // bus responder: checks each request against the queued expectation and answers with the planned timing
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      mem2proc_gnt = 1'b0;
      mem2proc_rvalid = 1'b0;
      if (proc2mem_req === 1'b1) begin
        if (bq.size() == 0) check("unexpected_req", 0, 1);
        else begin
          b = bq.pop_front();
          check("bus_req", {proc2mem_we, proc2mem_be, proc2mem_addr, proc2mem_wdata}, {b.we, b.be, b.addr, b.wdata});
          repeat (b.gd) begin
            @(negedge clk);
            check("req_hold", {proc2mem_req, proc2mem_we, proc2mem_be, proc2mem_addr, proc2mem_wdata},
                  {1'b1, b.we, b.be, b.addr, b.wdata});
          end
          mem2proc_gnt = 1'b1;
          if (!b.we && b.same) begin
            mem2proc_rvalid = 1'b1;
            mem2proc_rdata = b.rdata;
          end
          @(negedge clk);
          mem2proc_gnt = 1'b0;
          mem2proc_rvalid = 1'b0;
          if (!b.we && !b.same) begin
            repeat (b.ww) @(negedge clk);
            mem2proc_rvalid = 1'b1;
            mem2proc_rdata = b.rdata;
            @(negedge clk);
            mem2proc_rvalid = 1'b0;
          end
        end
      end else if ($urandom_range(3) == 0) begin
        mem2proc_rvalid = 1'b1;
        mem2proc_rdata = $urandom;
      end
    end
  end

  // monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (mem_done_out === 1'b1) begin
        if (rq.size() == 0) check("unexpected_done", 0, 1);
        else begin
          r = rq.pop_front();
          check("result", {mem_result_out, mem_err_out}, {r.r, r.e});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_t b;
    int dones;
    logic v, rd, wr;
    logic [2:0] f3;
    logic [31:0] alu;
    ex_mem_valid_inst = 1'b1;
    ex_mem_rd_mem = 1'b1;
    ex_mem_alu_result = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("reset_outputs", {proc2mem_req, proc2mem_we, proc2mem_be, mem_stall_out, mem_done_out, mem_err_out,
          proc2mem_addr, proc2mem_wdata, mem_result_out}, '0);
    ex_mem_valid_inst = 1'b0;
    ex_mem_rd_mem = 1'b0;
    rst = 1'b1;
    issue(1, 1, 0, 32'h0000_1003, 32'h0, 3'b000, 32'h80FF_0000, 0, 1, 0);
    issue(1, 0, 1, 32'h0000_2002, 32'h1234_ABCD, 3'b001, 32'h0, 3, 0, 0);
    issue(1, 1, 0, 32'h0000_2001, 32'h0, 3'b010, 32'h0, 0, 0, 0);
    issue(1, 1, 0, 32'h0000_0010, 32'h0, 3'b101, 32'h0000_F00F, 0, 0, 4);
    issue(1, 0, 0, 32'hDEAD_0001, 32'h0, 3'b000, 32'h0, 0, 0, 0);
    issue(1, 1, 1, 32'h0000_0004, 32'hFFFF_FFFF, 3'b010, 32'hCAFE_F00D, 1, 1, 0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) == 0) begin
        v = 1'($urandom_range(1));
        rd = v ? 1'b0 : 1'($urandom_range(1));
        wr = v ? 1'b0 : 1'($urandom_range(1));
      end else begin
        v = 1'b1;
        rd = 1'($urandom_range(1));
        wr = !rd || 1'($urandom_range(1));
      end
      f3 = $urandom_range(3) != 0 ? 3'($urandom_range(2)) | ($urandom_range(1) != 0 ? 3'b100 : 3'b000) : 3'($urandom_range(7));
      if (f3 == 3'b110) f3 = 3'b010;
      if ($urandom_range(9) == 0) f3 = 3'($urandom_range(7));
      alu = $urandom;
      if ($urandom_range(1) != 0) alu[1:0] = 2'b00;
      issue(v, rd, wr, alu, $urandom, f3, $urandom, $urandom_range(3), 1'($urandom_range(1)), $urandom_range(4));
    end
    b.addr = 32'h100;
    b.we = 1'b0;
    b.be = 4'hF;
    b.wdata = 32'h0;
    b.rdata = 32'h1234_5678;
    b.gd = 0;
    b.same = 1'b0;
    b.ww = 8;
    bq.push_back(b);
    @(posedge clk);
    #1;
    ex_mem_valid_inst = 1'b1;
    ex_mem_rd_mem = 1'b1;
    ex_mem_wr_mem = 1'b0;
    ex_mem_alu_result = 32'h100;
    ex_mem_regb = 32'h0;
    ex_mem_funct3 = 3'b010;
    repeat (3) @(negedge clk);
    check("wait_state", {mem_stall_out, proc2mem_req, mem_done_out}, 3'b100);
    rst = 1'b0;
    ex_mem_valid_inst = 1'b0;
    ex_mem_rd_mem = 1'b0;
    ex_mem_alu_result = 32'h0;
    #1;
    check("reset_mid_op", {proc2mem_req, proc2mem_we, proc2mem_be, mem_stall_out, mem_done_out, mem_err_out,
          proc2mem_addr, proc2mem_wdata, mem_result_out}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      dones += int'(mem_done_out);
    end
    check("no_done_after_reset", dones, 0);
    check("idle_after_reset", {proc2mem_req, mem_stall_out, mem_done_out, mem_err_out, mem_result_out}, '0);
    check("scoreboard_drained", {rq.size(), bq.size()}, '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
